ifm_prefetch: RTL and testbench

//   Instruction-fetch prefetcher. Pipelined Wishbone read master that drives arbiter slave port 1 (instruction side).

---
 rtl/ifm_prefetch.sv | 102 ++++++++++
 tb/tb_ifm_prefetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_prefetch.sv
// Instruction-fetch prefetcher: pipelined Wishbone read master feeding a PC/instruction FIFO.
// Redirects flush the FIFO and mark outstanding reads as stale so their acks are discarded.
module ifm_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW-1:0] count_q, inflight_q, drop_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   fetch_pc_q, resp_pc_q;
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic [CW:0]   pending;
  logic [31:0]   redirect_pc;
  logic          accept, ack_acc, push, pop;

  // Slots already promised to live reads count against FIFO space, so a push can never overflow.
  assign pending     = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
  assign redirect_pc = redirect_addr_i & ~32'h3;

  assign wb_stb_o = rst_ni && !redirect_i && (inflight_q < DEPTH_C) && (pending < DEPTH_W);
  assign wb_cyc_o = wb_stb_o || (inflight_q != '0);
  assign wb_adr_o = fetch_pc_q;
  assign wb_dat_o = '0;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = '1;

  assign accept  = wb_stb_o && !wb_stall_i;
  assign ack_acc = wb_ack_i && (inflight_q != '0);
  assign push    = ack_acc && (drop_q == '0) && !redirect_i;
  assign pop     = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_ADDR;
      resp_pc_q  <= RESET_ADDR;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      inflight_q <= inflight_q + CW'(accept) - CW'(ack_acc);
      if (redirect_i) begin
        // Every read still outstanding after this cycle's ack belongs to the old stream.
        drop_q     <= inflight_q - CW'(ack_acc);
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fetch_pc_q <= redirect_pc;
        resp_pc_q  <= redirect_pc;
      end else begin
        if (accept)
          fetch_pc_q <= fetch_pc_q + 32'd4;
        if (ack_acc && (drop_q != '0))
          drop_q <= drop_q - CW'(1);
        if (push) begin
          data_mem_q[wr_ptr_q] <= wb_dat_i;
          pc_mem_q[wr_ptr_q]   <= resp_pc_q;
          wr_ptr_q             <= wr_ptr_q + AW'(1);
          resp_pc_q            <= resp_pc_q + 32'd4;
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifm_prefetch.sv
// Directed bench for ifm_prefetch: a per-cycle vector table for streaming, backpressure and stall,
// followed by hand-written redirect and mid-burst reset sequences.
module tb_ifm_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_cyc_o;
  logic        wb_stall_i = 1'b0;

  int errors = 0;
  int checks = 0;

  ifm_prefetch #(
    .DEPTH(4),
    .RESET_ADDR(32'h0000_0000)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .instr_valid_o(instr_valid_o),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .wb_adr_o(wb_adr_o),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i),
    .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rdy;
    logic        stall;
    logic        ack;
    logic [31:0] dat;
    logic        stb;
    logic        cyc;
    logic [31:0] adr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rdy, input logic stall, input logic ack, input logic [31:0] dat,
                       input logic redir, input logic [31:0] raddr);
    instr_ready_i   = rdy;
    wb_stall_i      = stall;
    wb_ack_i        = ack;
    wb_dat_i        = dat;
    redirect_i      = redir;
    redirect_addr_i = raddr;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic do_reset(input bit check_state);
    rst_ni = 1'b0;
    apply(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    repeat (2) @(negedge clk_i);
    #1;
    if (check_state) begin
      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_pc", instr_pc_o, 32'h0);
      chk("rst_sel", 32'(wb_sel_o), 32'hF);
      chk("rst_we", 32'(wb_we_o), 32'd0);
      chk("rst_dat_o", wb_dat_o, 32'h0);
    end
    rst_ni = 1'b1;
  endtask

  task automatic set_tv(input int i, input logic rdy, input logic stall, input logic ack,
                        input logic [31:0] dat, input logic stb, input logic cyc,
                        input logic [31:0] adr, input logic vld, input logic [31:0] pc,
                        input logic [31:0] ins);
    tv[i].rdy = rdy; tv[i].stall = stall; tv[i].ack = ack; tv[i].dat = dat;
    tv[i].stb = stb; tv[i].cyc = cyc; tv[i].adr = adr;
    tv[i].vld = vld; tv[i].pc = pc; tv[i].ins = ins;
  endtask

  initial begin
    //      rdy stl ack dat           stb cyc adr     vld pc      instr
    set_tv( 0, 1, 0, 0, 32'h0,        1, 1, 32'h00, 0, 32'h00, 32'h0);
    set_tv( 1, 1, 0, 1, 32'hD0000000, 1, 1, 32'h04, 0, 32'h00, 32'h0);
    set_tv( 2, 1, 0, 1, 32'hD0000004, 1, 1, 32'h08, 1, 32'h00, 32'hD0000000);
    set_tv( 3, 1, 0, 1, 32'hD0000008, 1, 1, 32'h0C, 1, 32'h04, 32'hD0000004);
    set_tv( 4, 0, 0, 1, 32'hD000000C, 1, 1, 32'h10, 1, 32'h08, 32'hD0000008);
    set_tv( 5, 0, 0, 1, 32'hD0000010, 1, 1, 32'h14, 1, 32'h08, 32'hD0000008);
    set_tv( 6, 0, 0, 1, 32'hD0000014, 0, 1, 32'h18, 1, 32'h08, 32'hD0000008);
    set_tv( 7, 0, 0, 0, 32'h0,        0, 0, 32'h18, 1, 32'h08, 32'hD0000008);
    set_tv( 8, 1, 0, 0, 32'h0,        0, 0, 32'h18, 1, 32'h08, 32'hD0000008);
    set_tv( 9, 0, 0, 0, 32'h0,        1, 1, 32'h18, 1, 32'h0C, 32'hD000000C);
    set_tv(10, 0, 0, 1, 32'hD0000018, 0, 1, 32'h1C, 1, 32'h0C, 32'hD000000C);
    set_tv(11, 1, 0, 0, 32'h0,        0, 0, 32'h1C, 1, 32'h0C, 32'hD000000C);
    set_tv(12, 0, 1, 0, 32'h0,        1, 1, 32'h1C, 1, 32'h10, 32'hD0000010);
    set_tv(13, 0, 1, 0, 32'h0,        1, 1, 32'h1C, 1, 32'h10, 32'hD0000010);
    set_tv(14, 0, 1, 0, 32'h0,        1, 1, 32'h1C, 1, 32'h10, 32'hD0000010);
    set_tv(15, 0, 0, 0, 32'h0,        1, 1, 32'h1C, 1, 32'h10, 32'hD0000010);
    set_tv(16, 0, 0, 0, 32'h0,        0, 1, 32'h20, 1, 32'h10, 32'hD0000010);
    set_tv(17, 1, 0, 1, 32'hD000001C, 0, 1, 32'h20, 1, 32'h10, 32'hD0000010);
    set_tv(18, 0, 0, 0, 32'h0,        1, 1, 32'h20, 1, 32'h14, 32'hD0000014);

    // Streaming, FIFO full backpressure, pop-driven reissue, and address hold under stall.
    do_reset(1'b1);
    for (int i = 0; i < 19; i++) begin
      apply(tv[i].rdy, tv[i].stall, tv[i].ack, tv[i].dat, 1'b0, '0);
      chk($sformatf("v%0d_stb", i),   32'(wb_stb_o),      32'(tv[i].stb));
      chk($sformatf("v%0d_cyc", i),   32'(wb_cyc_o),      32'(tv[i].cyc));
      chk($sformatf("v%0d_adr", i),   wb_adr_o,           tv[i].adr);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid_o), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("v%0d_pc", i),    instr_pc_o, tv[i].pc);
        chk($sformatf("v%0d_instr", i), instr_o,    tv[i].ins);
      end
      next_cycle();
    end

    // Redirect with three reads outstanding: all three acks dropped, fetch resumes at 0x100.
    do_reset(1'b0);
    apply(0, 0, 0, '0, 0, '0); chk("a_adr0", wb_adr_o, 32'h0); next_cycle();
    apply(0, 0, 0, '0, 0, '0); chk("a_adr1", wb_adr_o, 32'h4); next_cycle();
    apply(0, 0, 0, '0, 0, '0); chk("a_adr2", wb_adr_o, 32'h8); next_cycle();
    apply(0, 0, 0, '0, 1, 32'h103);
    chk("a_redir_stb", 32'(wb_stb_o), 32'd0);
    chk("a_redir_cyc", 32'(wb_cyc_o), 32'd1);
    next_cycle();
    apply(0, 0, 1, 32'hAAAA0000, 0, '0);
    chk("a_new_stb", 32'(wb_stb_o), 32'd1);
    chk("a_new_adr", wb_adr_o, 32'h100);
    next_cycle();
    apply(0, 1, 1, 32'hBBBB0000, 0, '0); chk("a_drop_v1", 32'(instr_valid_o), 32'd0); next_cycle();
    apply(0, 1, 1, 32'hCCCC0000, 0, '0); chk("a_drop_v2", 32'(instr_valid_o), 32'd0); next_cycle();
    apply(0, 1, 1, 32'h12345678, 0, '0); chk("a_drop_v3", 32'(instr_valid_o), 32'd0); next_cycle();
    apply(0, 1, 0, '0, 0, '0);
    chk("a_head_valid", 32'(instr_valid_o), 32'd1);
    chk("a_head_pc", instr_pc_o, 32'h100);
    chk("a_head_instr", instr_o, 32'h12345678);
    chk("a_next_adr", wb_adr_o, 32'h104);
    next_cycle();

    // Redirect coinciding with an ack and a pop.
    do_reset(1'b0);
    apply(1, 0, 0, '0, 0, '0); chk("b_adr0", wb_adr_o, 32'h0); next_cycle();
    apply(1, 0, 0, '0, 0, '0); chk("b_adr1", wb_adr_o, 32'h4); next_cycle();
    apply(1, 0, 1, 32'h11111111, 0, '0);
    chk("b_adr2", wb_adr_o, 32'h8);
    chk("b_v_before", 32'(instr_valid_o), 32'd0);
    next_cycle();
    apply(1, 0, 1, 32'h22222222, 1, 32'h200);
    chk("b_redir_stb", 32'(wb_stb_o), 32'd0);
    chk("b_head_valid", 32'(instr_valid_o), 32'd1);
    chk("b_head_pc", instr_pc_o, 32'h0);
    chk("b_head_instr", instr_o, 32'h11111111);
    next_cycle();
    apply(1, 1, 0, '0, 0, '0);
    chk("b_flushed", 32'(instr_valid_o), 32'd0);
    chk("b_stb", 32'(wb_stb_o), 32'd1);
    chk("b_adr", wb_adr_o, 32'h200);
    next_cycle();
    apply(1, 1, 1, 32'h33333333, 0, '0); chk("b_stale_v", 32'(instr_valid_o), 32'd0); next_cycle();
    apply(1, 0, 0, '0, 0, '0);
    chk("b_after_drop_v", 32'(instr_valid_o), 32'd0);
    chk("b_hold_adr", wb_adr_o, 32'h200);
    next_cycle();
    apply(1, 1, 1, 32'h44444444, 0, '0); chk("b_pre_push_v", 32'(instr_valid_o), 32'd0); next_cycle();
    apply(0, 1, 0, '0, 0, '0);
    chk("b_push_valid", 32'(instr_valid_o), 32'd1);
    chk("b_push_pc", instr_pc_o, 32'h200);
    chk("b_push_instr", instr_o, 32'h44444444);
    next_cycle();

    // Asynchronous reset with two reads in flight, then a stray ack.
    do_reset(1'b0);
    apply(0, 0, 0, '0, 0, '0); chk("c_adr0", wb_adr_o, 32'h0); next_cycle();
    apply(0, 0, 0, '0, 0, '0); chk("c_adr1", wb_adr_o, 32'h4); next_cycle();
    rst_ni = 1'b0;
    #1;
    chk("c_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("c_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("c_rst_adr", wb_adr_o, 32'h0);
    next_cycle();
    rst_ni = 1'b1;
    apply(0, 1, 1, 32'hDEADBEEF, 0, '0);
    chk("c_restart_stb", 32'(wb_stb_o), 32'd1);
    chk("c_restart_adr", wb_adr_o, 32'h0);
    next_cycle();
    apply(0, 1, 0, '0, 0, '0);
    chk("c_stray_valid", 32'(instr_valid_o), 32'd0);
    chk("c_stray_cyc", 32'(wb_cyc_o), 32'd1);
    chk("c_stray_adr", wb_adr_o, 32'h0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
